// File: rtl/mbscore_mem_access_pkg.sv
// Constants and types shared by the memory-access stage and the writeback mux.
package mbscore_mem_access_pkg;

  localparam int MBS_DATA_WIDTH = 32;

  // Writeback select codes
  localparam logic [1:0] WB_SEL_ALU_TO_IR  = 2'd0;
  localparam logic [1:0] WB_SEL_ALU_TO_REG = 2'd1;
  localparam logic [1:0] WB_SEL_ALU_TO_MEM = 2'd2;  // store
  localparam logic [1:0] WB_SEL_MEM_TO_REG = 2'd3;  // load

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // True for the selects that need a data-memory transaction.
  function automatic logic sel_is_mem(input logic [1:0] sel);
    return (sel == WB_SEL_ALU_TO_MEM) || (sel == WB_SEL_MEM_TO_REG);
  endfunction

endpackage

// File: rtl/mbscore_mem_access_watchdog.sv
// Ack-timeout counter for the memory-access stage.
// Counts cycles spent waiting for mem_ack while 'run' is high. 'expired'
// rises in the cycle that would be the TIMEOUT-th consecutive wait cycle,
// so the owner completes after exactly TIMEOUT cycles without an ack.
// TIMEOUT must be at least 1.
module mbscore_mem_access_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int               CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: cleared outside a transaction, saturates at the last wait cycle.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (that would infer a latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/mbscore_mem_access.sv
// Memory-access pipeline stage: passes ALU results straight to writeback,
// or performs one data-memory load/store and then hands the result on.
// The writeback output register is a one-entry buffer with valid/ready.
module mbscore_mem_access
  import mbscore_mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = MBS_DATA_WIDTH,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // EX stage
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [1:0]            ex_WB_sel,
  input  logic [DATA_WIDTH-1:0] ex_alu_out,
  input  logic [ADDR_WIDTH-1:0] ex_mem_addr,
  // Data memory
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // Writeback
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [1:0]            WB_sel,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_err
);

  state_e                state_q,       state_d;
  logic                  mem_req_q,     mem_req_d;
  logic                  mem_we_q,      mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;
  logic                  wb_valid_q,    wb_valid_d;
  logic [1:0]            wb_sel_q,      wb_sel_d;
  logic [DATA_WIDTH-1:0] alu_out_q,     alu_out_d;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
  logic                  mem_err_q,     mem_err_d;

  logic in_access;
  logic ex_fire;
  logic wd_run;
  logic wd_clr;
  logic wd_expired;

  assign in_access = (state_q == ST_ACCESS);
  assign ex_ready  = (state_q == ST_IDLE) && (!wb_valid_q || wb_ready);
  assign ex_fire   = ex_valid && ex_ready;

  // The counter only runs on ack-less ACCESS cycles; an ack in the
  // would-be timeout cycle therefore wins over the timeout.
  assign wd_run = in_access && !mem_ack;
  assign wd_clr = !in_access;

  mbscore_mem_access_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .run     (wd_run),
    .expired (wd_expired)
  );

  // Next-state, memory request and writeback buffer update.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wb_valid_d    = wb_valid_q;
    wb_sel_d      = wb_sel_q;
    alu_out_d     = alu_out_q;
    mem_data_in_d = mem_data_in_q;
    mem_err_d     = mem_err_q;

    // Drain first; a load below on the same edge re-asserts valid.
    if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ex_fire) begin
          if (sel_is_mem(ex_WB_sel)) begin
            state_d     = ST_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = (ex_WB_sel == WB_SEL_ALU_TO_MEM);
            mem_addr_d  = ex_mem_addr;
            mem_wdata_d = ex_alu_out;
          end else begin
            wb_valid_d    = 1'b1;
            wb_sel_d      = ex_WB_sel;
            alu_out_d     = ex_alu_out;
            mem_data_in_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        // The buffer is always empty here: an op is only accepted when the
        // buffer drains on that edge, and nothing else loads it meanwhile.
        // The accepted op's ALU value is still held in mem_wdata_q.
        if (mem_ack || wd_expired) begin
          state_d       = ST_IDLE;
          mem_req_d     = 1'b0;
          wb_valid_d    = 1'b1;
          wb_sel_d      = mem_we_q ? WB_SEL_ALU_TO_MEM : WB_SEL_MEM_TO_REG;
          alu_out_d     = mem_wdata_q;
          mem_data_in_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          if (!mem_ack) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_sel_q      <= WB_SEL_ALU_TO_IR;
      alu_out_q     <= '0;
      mem_data_in_q <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_sel_q      <= wb_sel_d;
      alu_out_q     <= alu_out_d;
      mem_data_in_q <= mem_data_in_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign WB_sel      = wb_sel_q;
  assign alu_out     = alu_out_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_err     = mem_err_q;

endmodule

// File: doc/mbscore_mem_access.md
MBSCORE_MEM_ACCESS -- requirements
Module: MBScore_mem_access

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), datapath width.
REQ-002 Parameter ADDR_WIDTH, default 16, data-memory address width.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for mem_ack.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ex_valid  in  1  EX stage presents an op.
REQ-007 ex_ready  out  1  stage accepts the op this cycle.
REQ-008 ex_WB_sel  in  2  writeback select: 0 ALUtoIR, 1 ALUtoReg, 2 ALUtoMEM (store), 3 MEMtoReg (load).
REQ-009 ex_alu_out  in  DATA_WIDTH  ALU result; store data for sel 2.
REQ-010 ex_mem_addr  in  ADDR_WIDTH  memory address for sel 2/3.
REQ-011 mem_req  out  1  memory request.
REQ-012 mem_we  out  1  1 = write (store), 0 = read (load).
REQ-013 mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH.
REQ-014 mem_ack  in  1  memory completion; mem_rdata  in  DATA_WIDTH, valid with mem_ack.
REQ-015 wb_valid  out  1; wb_ready  in  1  handshake toward the writeback mux.
REQ-016 WB_sel  out  2; alu_out  out  DATA_WIDTH; mem_data_in  out  DATA_WIDTH  registered operands for writeback.
REQ-017 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-018 FSM states IDLE, ACCESS; the output register (wb_valid plus payload) is a one-entry buffer.
REQ-019 ex_ready = (state==IDLE) && (!wb_valid || wb_ready); a transfer occurs when ex_valid && ex_ready.
REQ-020 For sel 0/1: on transfer, payload loads the output register next edge; wb_valid=1, mem_data_in=0; latency 1 cycle.
REQ-021 For sel 2/3: on transfer, go to ACCESS; mem_req=1, mem_we=(sel==2), mem_addr=ex_mem_addr, mem_wdata=ex_alu_out, all registered and held stable until completion.
REQ-022 In ACCESS, on mem_ack: drop mem_req next edge, load output register (mem_data_in=mem_rdata for loads, 0 for stores), wb_valid=1, return to IDLE; latency = 1 + ack wait cycles.
REQ-023 The output register clears wb_valid when wb_valid && wb_ready and no new load occurs the same edge; a simultaneous drain and load keeps wb_valid=1 with the new payload.
REQ-024 mem_ack outside ACCESS is ignored.
REQ-025 A wait counter increments each ACCESS cycle without ack; at count==TIMEOUT, complete as in REQ-022 with mem_data_in=0 and set mem_err=1.
REQ-026 mem_ack in the same cycle the timeout is reached wins: normal completion, mem_err unchanged.
REQ-027 mem_err remains set until reset; the stage keeps operating normally.
REQ-028 Payload and WB_sel remain stable while wb_valid && !wb_ready.

Reset
REQ-029 On rst: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, WB_sel=0, alu_out=0, mem_data_in=0, mem_err=0.
REQ-030 rst during ACCESS abandons the transaction: mem_req=0 after that edge, no wb_valid is produced, and a late mem_ack is ignored.

Structure
REQ-031 DATA_WIDTH and the WB_SEL_* codes (including ALUtoIR=0) reside in the shared MBScore_const.v header; this block and the writeback mux both use them.
REQ-032 The ack-timeout counter is a sub-module, MBScore_mem_watchdog (inputs: clr, run; output: expired).

Verification
REQ-033 sel=1, alu_out=0x1234, wb_ready=1 -> one cycle later wb_valid=1, WB_sel=1, alu_out=0x1234, mem_data_in=0, mem_req never asserted.
REQ-034 sel=3, addr=0x0040, ack after 3 cycles with rdata=0xDEADBEEF -> mem_req high 3 cycles with mem_we=0, addr=0x0040; then wb_valid=1, mem_data_in=0xDEADBEEF; ex_ready=0 throughout.
REQ-035 sel=2, alu_out=0xCAFE, addr=0x0010, immediate ack -> mem_we=1, mem_wdata=0xCAFE for 1 cycle; wb_valid=1, WB_sel=2, mem_data_in=0.
REQ-036 TIMEOUT=4, load, no ack -> mem_req drops after 4 wait cycles, mem_err=1, mem_data_in=0; the next sel=1 op still completes.
REQ-037 wb_ready=0 holding wb_valid -> ex_ready=0 and payload stable; release with ex_valid=1 -> drain and new load on the same edge, with no bubble.
REQ-038 rst pulsed in the 2nd ACCESS cycle, then mem_ack -> all outputs 0, no wb_valid, mem_err=0.
